// File: rtl/ex_mem_buffer_if.sv
// Execute-to-memory handshake bundle: producer side (in_*) and consumer side (out_*).
// Latency: none; this is wiring only.
// Backpressure: in_ready / out_ready travel in opposite directions to their valids.
interface ex_mem_buffer_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_ofl;
    logic              in_z;
    logic [DATA_W-1:0] in_store_data;
    logic [REG_W-1:0]  in_wr_reg;
    logic              in_wr_en;
    logic              in_mem_rd;
    logic              in_mem_wr;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_ofl;
    logic              out_z;
    logic [DATA_W-1:0] out_store_data;
    logic [REG_W-1:0]  out_wr_reg;
    logic              out_wr_en;
    logic              out_mem_rd;
    logic              out_mem_wr;

    // Surrounding pipeline view: drives execute-side entries, consumes memory-side entries.
    modport master (
        output in_valid, in_result, in_ofl, in_z, in_store_data,
               in_wr_reg, in_wr_en, in_mem_rd, in_mem_wr, out_ready,
        input  in_ready, out_valid, out_result, out_ofl, out_z,
               out_store_data, out_wr_reg, out_wr_en, out_mem_rd, out_mem_wr
    );

    // Buffer view.
    modport slave (
        input  in_valid, in_result, in_ofl, in_z, in_store_data,
               in_wr_reg, in_wr_en, in_mem_rd, in_mem_wr, out_ready,
        output in_ready, out_valid, out_result, out_ofl, out_z,
               out_store_data, out_wr_reg, out_wr_en, out_mem_rd, out_mem_wr
    );
endinterface

// File: rtl/ex_mem_buffer.sv
// Two-entry elastic EX/MEM buffer (main + skid register) with flush; optional sticky overflow via OFL_STICKY_EN.
// Latency: entry accepted at edge N appears on out_* right after edge N.
// Backpressure: in_ready = ~skid_v straight from a flop; one extra entry absorbed when out_ready drops.
module ex_mem_buffer #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ofl_clr,
    output logic              ofl_sticky,
    ex_mem_buffer_if.slave    bus
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              ofl;
        logic              z;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  wr_reg;
        logic              wr_en;
        logic              mem_rd;
        logic              mem_wr;
    } entry_t;

    // Encoding is {main_v, skid_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t state;
    entry_t in_ent;
    entry_t main_q;
    entry_t skid_q;
    logic   main_v;
    logic   skid_v;
    logic   accept;
    logic   pop;

    assign main_v = state[1];
    assign skid_v = state[0];
    assign accept = bus.in_valid & ~skid_v;
    assign pop    = main_v & bus.out_ready;

    // Pack the incoming execute-stage fields into one entry.
    always_comb begin
        in_ent            = '0;
        in_ent.result     = bus.in_result;
        in_ent.ofl        = bus.in_ofl;
        in_ent.z          = bus.in_z;
        in_ent.store_data = bus.in_store_data;
        in_ent.wr_reg     = bus.in_wr_reg;
        in_ent.wr_en      = bus.in_wr_en;
        in_ent.mem_rd     = bus.in_mem_rd;
        in_ent.mem_wr     = bus.in_mem_wr;
    end

    // Occupancy FSM plus main/skid data registers; flush empties without touching data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_ent;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_q <= in_ent;
                    end else if (accept) begin
                        skid_q <= in_ent;
                        state  <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.in_ready       = ~skid_v;
    assign bus.out_valid      = main_v;
    assign bus.out_result     = main_q.result;
    assign bus.out_ofl        = main_q.ofl;
    assign bus.out_z          = main_q.z;
    assign bus.out_store_data = main_q.store_data;
    assign bus.out_wr_reg     = main_q.wr_reg;
    assign bus.out_wr_en      = main_q.wr_en;
    assign bus.out_mem_rd     = main_q.mem_rd;
    assign bus.out_mem_wr     = main_q.mem_wr;

`ifdef OFL_STICKY_EN
    logic sticky_q;

    // A consumed writeback with overflow sets the flag; set beats a same-cycle clear.
    // Flushed entries are never popped, so they cannot set it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (pop && main_q.ofl && main_q.wr_en) begin
            sticky_q <= 1'b1;
        end else if (ofl_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign ofl_sticky = sticky_q;
`else
    logic unused_ofl_clr;
    assign unused_ofl_clr = ofl_clr;
    assign ofl_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed bench for ex_mem_buffer: reset, single entry, streaming, skid backpressure, flush, sticky overflow, async reset.
// Latency: inputs change 1ns after a rising edge, outputs checked 1ns after the next rising edge.
// Backpressure: exercised via out_ready low to fill the skid register.
module tb_ex_mem_buffer;

`ifdef OFL_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic flush;
    logic ofl_clr;
    logic ofl_sticky;
    int   n_vec;
    int   n_err;

    ex_mem_buffer_if #(.DATA_W(16), .REG_W(3)) bus ();

    ex_mem_buffer #(.DATA_W(16), .REG_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .ofl_clr    (ofl_clr),
        .ofl_sticky (ofl_sticky),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid      = 1'b0;
        bus.in_result     = '0;
        bus.in_ofl        = 1'b0;
        bus.in_z          = 1'b0;
        bus.in_store_data = '0;
        bus.in_wr_reg     = '0;
        bus.in_wr_en      = 1'b0;
        bus.in_mem_rd     = 1'b0;
        bus.in_mem_wr     = 1'b0;
    endtask

    task automatic drive(input logic [15:0] res, input logic [2:0] rg, input logic ofl, input logic wen);
        bus.in_valid      = 1'b1;
        bus.in_result     = res;
        bus.in_ofl        = ofl;
        bus.in_z          = (res == 16'h0);
        bus.in_store_data = ~res;
        bus.in_wr_reg     = rg;
        bus.in_wr_en      = wen;
        bus.in_mem_rd     = res[0];
        bus.in_mem_wr     = res[1];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; ofl_clr = 1'b0; bus.out_ready = 1'b0;
        idle_inputs();
        #12;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_result !== 16'h0 || bus.out_wr_reg !== 3'h0) begin n_err++; $display("FAIL reset_fields got %h/%h want 0/0", bus.out_result, bus.out_wr_reg); end
        n_vec++; if (ofl_sticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky got %b want 0", ofl_sticky); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        drive(16'h1234, 3'd3, 1'b0, 1'b1);
        tick();
        idle_inputs();
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
        n_vec++; if (bus.out_result !== 16'h1234) begin n_err++; $display("FAIL single_result got %h want 1234", bus.out_result); end
        n_vec++; if (bus.out_wr_reg !== 3'd3 || bus.out_store_data !== 16'hedcb) begin n_err++; $display("FAIL single_fields got %h/%h want 3/edcb", bus.out_wr_reg, bus.out_store_data); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready got %b want 1", bus.in_ready); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(16'h0100 + 16'(i), 3'(i), 1'b0, 1'b1);
            tick();
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0100 + 16'(i)) begin
                n_err++; $display("FAIL stream_%0d got v=%b r=%h want v=1 r=%h", i, bus.out_valid, bus.out_result, 16'h0100 + 16'(i)); end
            n_vec++; if (bus.in_ready !== 1'b1 || bus.out_wr_reg !== 3'(i)) begin
                n_err++; $display("FAIL stream_rdy_%0d got rdy=%b reg=%0d want 1/%0d", i, bus.in_ready, bus.out_wr_reg, i); end
        end
        idle_inputs();
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(16'haaa2, 3'd5, 1'b0, 1'b1);
        tick();
        n_vec++; if (bus.in_ready !== 1'b1 || bus.out_result !== 16'haaa2) begin n_err++; $display("FAIL bp_one got rdy=%b r=%h want 1/aaa2", bus.in_ready, bus.out_result); end
        drive(16'hbbb1, 3'd6, 1'b0, 1'b1);
        tick();
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_rdy got %b want 0", bus.in_ready); end
        n_vec++; if (bus.out_result !== 16'haaa2 || bus.out_mem_wr !== 1'b1 || bus.out_mem_rd !== 1'b0) begin
            n_err++; $display("FAIL bp_full_head got %h wr=%b rd=%b want aaa2/1/0", bus.out_result, bus.out_mem_wr, bus.out_mem_rd); end
        drive(16'hdead, 3'd7, 1'b0, 1'b1);
        tick();
        n_vec++; if (bus.out_result !== 16'haaa2 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold got %h rdy=%b want aaa2/0", bus.out_result, bus.in_ready); end
        idle_inputs();
        bus.out_ready = 1'b1;
        tick();
        n_vec++; if (bus.out_result !== 16'hbbb1 || bus.out_wr_reg !== 3'd6 || bus.out_mem_rd !== 1'b1) begin
            n_err++; $display("FAIL bp_pop_a got %h reg=%0d rd=%b want bbb1/6/1", bus.out_result, bus.out_wr_reg, bus.out_mem_rd); end
        n_vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_rdy_back got rdy=%b v=%b want 1/1", bus.in_ready, bus.out_valid); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_pop_b got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(16'h1111, 3'd1, 1'b0, 1'b1); tick();
        drive(16'h2222, 3'd2, 1'b0, 1'b1); tick();
        drive(16'hcccc, 3'd4, 1'b0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_inputs();
        n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_full got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
        bus.out_ready = 1'b1;
        tick(); tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_c got %b want 0", bus.out_valid); end
        bus.out_ready = 1'b0;
        drive(16'h3333, 3'd3, 1'b0, 1'b1); tick();
        drive(16'h4444, 3'd4, 1'b0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_inputs();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_accept got %b want 0", bus.out_valid); end
    endtask

    task automatic test_sticky();
        logic exp_set;
        exp_set = STICKY_ON;
        bus.out_ready = 1'b1;
        drive(16'h0ff0, 3'd2, 1'b1, 1'b0); tick(); idle_inputs(); tick();
        n_vec++; if (ofl_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_no_wen got %b want 0", ofl_sticky); end
        drive(16'h7ff0, 3'd2, 1'b1, 1'b1); tick(); idle_inputs();
        n_vec++; if (bus.out_ofl !== 1'b1) begin n_err++; $display("FAIL sticky_head_ofl got %b want 1", bus.out_ofl); end
        tick();
        n_vec++; if (ofl_sticky !== exp_set) begin n_err++; $display("FAIL sticky_set got %b want %b", ofl_sticky, exp_set); end
        drive(16'h7ff4, 3'd3, 1'b1, 1'b1); tick(); idle_inputs();
        ofl_clr = 1'b1;
        tick();
        n_vec++; if (ofl_sticky !== exp_set) begin n_err++; $display("FAIL sticky_set_wins got %b want %b", ofl_sticky, exp_set); end
        tick();
        ofl_clr = 1'b0;
        n_vec++; if (ofl_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_clr got %b want 0", ofl_sticky); end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        drive(16'h5555, 3'd5, 1'b1, 1'b1); tick();
        drive(16'h6666, 3'd6, 1'b0, 1'b1); tick();
        idle_inputs();
        n_vec++; if (bus.in_ready !== 1'b0 || bus.out_result !== 16'h5555) begin n_err++; $display("FAIL areset_pre got rdy=%b r=%h want 0/5555", bus.in_ready, bus.out_result); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL areset_ctl got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
        n_vec++; if (bus.out_result !== 16'h0 || bus.out_wr_reg !== 3'h0 || bus.out_ofl !== 1'b0 || bus.out_store_data !== 16'h0) begin
            n_err++; $display("FAIL areset_fields got %h/%h/%b/%h want 0", bus.out_result, bus.out_wr_reg, bus.out_ofl, bus.out_store_data); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL areset_after got %b want 0", bus.out_valid); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_sticky();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
